// File: rtl/mfp_bot_irq_sched.sv
// Round-robin update-interrupt scheduler: latches source events and hands them to the core one at a time.
// Optional per-source arbitration mask is enabled with `define IRQ_MASK_EN.
module mfp_bot_irq_sched #(
  parameter int SRC_W       = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int OVR_W       = 8
) (
  input  logic                      clk1_in,
  input  logic                      reset,
  input  logic [(1 << SRC_W)-1:0]   IO_Src_Updt,
  input  logic                      IO_INT_ACK,
`ifdef IRQ_MASK_EN
  input  logic [(1 << SRC_W)-1:0]   IO_IntMask,
`endif
  output logic                      IO_BotUpdt_Sync,
  output logic [SRC_W-1:0]          IO_IntSrc,
  output logic [(1 << SRC_W)-1:0]   IO_Pending,
  output logic [OVR_W-1:0]          IO_Overrun_Cnt,
  output logic                      IO_Timeout
);

  localparam int NSRC  = 1 << SRC_W;
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_DROP} state_t;

  state_t           state;
  logic [NSRC-1:0]  src_q;
  logic [SRC_W-1:0] rr_ptr;
  logic [TMR_W-1:0] timer;

  logic [NSRC-1:0]  rise;
  logic [NSRC-1:0]  eligible;
  logic [NSRC-1:0]  grant_clr;
  logic             gnt_found;
  logic [SRC_W-1:0] gnt_id;
  logic [SRC_W-1:0] idx;
  logic             overrun_hit;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rise = IO_Src_Updt & ~src_q;

`ifdef IRQ_MASK_EN
  assign eligible = IO_Pending & ~IO_IntMask;
`else
  assign eligible = IO_Pending;
`endif

  // Rotating priority: first eligible source at or above rr_ptr, wrapping modulo NSRC.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = rr_ptr + SRC_W'(k);
      if (!gnt_found && eligible[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  assign grant_clr   = (state == IDLE && gnt_found) ? (NSRC'(1) << gnt_id) : '0;
  // A rise on the source being granted this cycle re-arms it rather than counting as lost.
  assign overrun_hit = |(rise & IO_Pending & ~grant_clr);

  always_ff @(posedge clk1_in) begin
    if (reset) begin
      state           <= IDLE;
      src_q           <= '0;
      rr_ptr          <= '0;
      timer           <= '0;
      IO_BotUpdt_Sync <= 1'b0;
      IO_IntSrc       <= '0;
      IO_Pending      <= '0;
      IO_Overrun_Cnt  <= '0;
      IO_Timeout      <= 1'b0;
    end else begin
      src_q      <= IO_Src_Updt;
      IO_Pending <= (IO_Pending & ~grant_clr) | rise;
      if (overrun_hit) IO_Overrun_Cnt <= sat_inc(IO_Overrun_Cnt);
      case (state)
        IDLE: begin
          if (gnt_found) begin
            IO_IntSrc       <= gnt_id;
            rr_ptr          <= gnt_id + SRC_W'(1);
            IO_BotUpdt_Sync <= 1'b1;
            timer           <= '0;
            state           <= ASSERT;
          end
        end
        ASSERT: begin
          if (IO_INT_ACK) begin
            IO_BotUpdt_Sync <= 1'b0;
            state           <= WAIT_DROP;
          end else if (timer == TMR_LAST) begin
            IO_BotUpdt_Sync <= 1'b0;
            IO_Timeout      <= 1'b1;
            state           <= WAIT_DROP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DROP: begin
          if (!IO_INT_ACK) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
